fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter_if.sv | 39 +++
 rtl/fifo_wr_arbiter.sv | 115 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-write bundle for fifo_wr_arbiter; master = arbiter side, slave = requesters + FIFO.
// wcount exists only when FIFO_ARB_STATS_EN is defined.
interface fifo_wr_arbiter_if #(
    parameter int DSIZE = 8,
    parameter int NREQ  = 4
);
    localparam int OW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       ack;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic                  wfull;
    logic                  walmostfull;
    logic [OW-1:0]         owner;
    logic                  busy;
`ifdef FIFO_ARB_STATS_EN
    logic [15:0]           wcount;

    modport master (
        input  req, req_data, wfull, walmostfull,
        output ack, winc, wdata, owner, busy, wcount
    );
    modport slave (
        output req, req_data, wfull, walmostfull,
        input  ack, winc, wdata, owner, busy, wcount
    );
`else
    modport master (
        input  req, req_data, wfull, walmostfull,
        output ack, winc, wdata, owner, busy
    );
    modport slave (
        output req, req_data, wfull, walmostfull,
        input  ack, winc, wdata, owner, busy
    );
`endif
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter into a FIFO write port; winc/ack are combinational in GRANT, wfull stalls,
// walmostfull only blocks new grants. FIFO_ARB_STATS_EN adds a saturating winc counter (wcount).
module fifo_wr_arbiter #(
    parameter int DSIZE = 8,
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic              wclk,
    input  logic              wrst,
    fifo_wr_arbiter_if.master bus
);
    localparam int OW = $clog2(NREQ);
    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [OW-1:0] r_owner, w_owner_nxt;
    logic [OW-1:0] r_last, w_last_nxt;
    logic [OW-1:0] w_sel, w_cand;
    logic          w_sel_vld;
    logic          w_req_own;
    logic          w_xfer;
    logic [NREQ-1:0] w_ack;

    // First requester at or after last_owner+1, wrapping.
    always_comb begin
        w_sel     = '0;
        w_sel_vld = 1'b0;
        w_cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = OW'((int'(r_last) + k) % NREQ);
            if (!w_sel_vld && bus.req[w_cand]) begin
                w_sel_vld = 1'b1;
                w_sel     = w_cand;
            end
        end
    end

    assign w_req_own = bus.req[r_owner];
    assign w_xfer    = (r_state == GRANT) && w_req_own && !bus.wfull;

    always_comb begin
        w_ack = '0;
        if (w_xfer) w_ack[r_owner] = 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                if (w_sel_vld && !bus.walmostfull) begin
                    w_state_nxt = GRANT;
                    w_owner_nxt = w_sel;
                    w_cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (!w_req_own) begin
                    w_state_nxt = IDLE;
                    w_last_nxt  = r_owner;
                end else if (w_xfer) begin
                    if (r_cnt == CW'(BURST - 1)) begin
                        w_state_nxt = IDLE;
                        w_last_nxt  = r_owner;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_owner <= '0;
            r_last  <= OW'(NREQ - 1);
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign bus.winc  = w_xfer;
    assign bus.ack   = w_ack;
    assign bus.wdata = bus.req_data[int'(r_owner)*DSIZE +: DSIZE];
    assign bus.owner = r_owner;
    assign bus.busy  = (r_state == GRANT);

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] r_wcount;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_wcount <= '0;
        end else if (w_xfer && (r_wcount != 16'hFFFF)) begin
            r_wcount <= r_wcount + 16'd1;
        end
    end

    assign bus.wcount = r_wcount;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed scenarios then random traffic, checked every cycle against a transaction-level model.
module tb_fifo_wr_arbiter;
    localparam int DSIZE = 8;
    localparam int NREQ  = 4;
    localparam int BURST = 4;

    logic wclk = 1'b0;
    logic wrst;
    always #5 wclk = ~wclk;

    fifo_wr_arbiter_if #(.DSIZE(DSIZE), .NREQ(NREQ)) ifc ();

    fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .BURST(BURST)) dut (
        .wclk (wclk),
        .wrst (wrst),
        .bus  (ifc)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Requester-side word queues; a dropped requester keeps its word but lowers req.
    logic [DSIZE-1:0] q [NREQ][$];
    logic [NREQ-1:0]  drop;

    // Reference model: a burst is "in progress" for an owner, words counted, last winner remembered.
    bit m_busy;
    int m_owner, m_words, m_last, m_total;

    int  dut_log[$];
    bit  prev_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DSIZE-1:0] front(input int i);
        return (q[i].size() != 0) ? q[i][0] : '0;
    endfunction

    // Round-robin: requester with the smallest distance past the last winner.
    function automatic int pick(input logic [NREQ-1:0] r);
        int best = 0;
        int bestd = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            int d = (i - m_last - 1 + 2 * NREQ) % NREQ;
            if (r[i] && d < bestd) begin
                bestd = d;
                best  = i;
            end
        end
        return best;
    endfunction

    function automatic bit settled();
        bit s = !m_busy;
        for (int i = 0; i < NREQ; i++)
            if (q[i].size() != 0 && !drop[i]) s = 1'b0;
        return s;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_words = 0;
        m_last  = NREQ - 1;
        m_total = 0;
    endtask

    task automatic drive();
        logic [NREQ-1:0]       r;
        logic [NREQ*DSIZE-1:0] d;
        for (int i = 0; i < NREQ; i++) begin
            r[i] = (q[i].size() != 0) && !drop[i];
            d[i*DSIZE +: DSIZE] = front(i);
        end
        ifc.req      = r;
        ifc.req_data = d;
    endtask

    task automatic cycle();
        bit              exp_winc;
        logic [NREQ-1:0] exp_ack;
        drive();
        @(negedge wclk);
        if (wrst) model_reset();
        exp_winc = m_busy && ifc.req[m_owner] && !ifc.wfull;
        exp_ack  = '0;
        if (exp_winc) exp_ack[m_owner] = 1'b1;
        chk("busy",  32'(ifc.busy),  32'(m_busy));
        chk("owner", 32'(ifc.owner), 32'(m_owner));
        chk("winc",  32'(ifc.winc),  32'(exp_winc));
        chk("ack",   32'(ifc.ack),   32'(exp_ack));
        if (m_busy) chk("wdata", 32'(ifc.wdata), 32'(front(m_owner)));
`ifdef FIFO_ARB_STATS_EN
        chk("wcount", 32'(ifc.wcount), 32'(m_total));
`endif
        if (ifc.busy && !prev_busy) dut_log.push_back(int'(ifc.owner));
        prev_busy = ifc.busy;
        if (!wrst) begin
            if (!m_busy) begin
                if (ifc.req != '0 && !ifc.walmostfull) begin
                    m_owner = pick(ifc.req);
                    m_busy  = 1'b1;
                    m_words = 0;
                end
            end else if (!ifc.req[m_owner]) begin
                m_busy = 1'b0;
                m_last = m_owner;
            end else if (exp_winc) begin
                m_words++;
                if (m_total < 65535) m_total++;
                void'(q[m_owner].pop_front());
                if (m_words == BURST) begin
                    m_busy = 1'b0;
                    m_last = m_owner;
                end
            end
        end
        @(posedge wclk);
        #1;
    endtask

    task automatic settle(input string tag, input int budget);
        for (int n = 0; n < budget && !settled(); n++) cycle();
        chk(tag, 32'(settled()), 32'd1);
    endtask

    task automatic reset_pulse();
        wrst = 1'b1;
        cycle();
        wrst = 1'b0;
    endtask

    initial begin
        wrst            = 1'b1;
        drop            = '0;
        ifc.wfull       = 1'b0;
        ifc.walmostfull = 1'b0;
        ifc.req         = '0;
        ifc.req_data    = '0;
        prev_busy       = 1'b0;
        model_reset();
        #1;
        cycle();
        cycle();
        wrst = 1'b0;

        // Single requester, six words: burst of four, gap, burst of two.
        for (int k = 0; k < 6; k++) q[0].push_back(8'(8'h10 + k));
        settle("single_done", 40);
        chk("single_bursts", 32'(dut_log.size()), 32'd2);
        if (dut_log.size() == 2) chk("single_regrant", 32'(dut_log[1]), 32'd0);

        // Contention from reset: owners 0,1,2,3,0.
        reset_pulse();
        dut_log.delete();
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < ((i == 0) ? 8 : 4); k++) q[i].push_back(8'(16 * i + k));
        settle("contend_done", 80);
        chk("contend_bursts", 32'(dut_log.size()), 32'd5);
        for (int j = 0; j < 5 && j < dut_log.size(); j++)
            chk("contend_order", 32'(dut_log[j]), 32'(j % NREQ));

        // Full stall for three cycles after word two.
        for (int k = 0; k < 4; k++) q[1].push_back(8'(8'hA0 + k));
        for (int n = 0; n < 20 && q[1].size() > 2; n++) cycle();
        chk("stall_reach", 32'(q[1].size()), 32'd2);
        ifc.wfull = 1'b1;
        repeat (3) cycle();
        chk("stall_held", 32'(q[1].size()), 32'd2);
        ifc.wfull = 1'b0;
        settle("stall_done", 20);

        // Almost-full blocks the grant; release grants owner 1.
        dut_log.delete();
        ifc.walmostfull = 1'b1;
        q[1].push_back(8'h5A);
        repeat (3) cycle();
        chk("afull_nogrant", 32'(dut_log.size()), 32'd0);
        ifc.walmostfull = 1'b0;
        settle("afull_done", 10);
        chk("afull_owner", 32'(ifc.owner), 32'd1);

        // Early drop by requester 2 hands over to 3.
        dut_log.delete();
        for (int k = 0; k < 4; k++) begin
            q[2].push_back(8'(8'hC0 + k));
            q[3].push_back(8'(8'hD0 + k));
        end
        for (int n = 0; n < 20 && q[2].size() > 2; n++) cycle();
        chk("drop_reach", 32'(q[2].size()), 32'd2);
        drop[2] = 1'b1;
        settle("drop_done", 30);
        chk("drop_next", 32'(dut_log.size() >= 2 ? dut_log[1] : -1), 32'd3);
        drop[2] = 1'b0;
        settle("drop_resume", 30);

        // Reset during the first word of owner 2.
        for (int k = 0; k < 4; k++) q[2].push_back(8'(8'hE0 + k));
        for (int n = 0; n < 20 && !(m_busy && m_owner == 2); n++) cycle();
        chk("rst_reach", 32'(m_busy && m_owner == 2), 32'd1);
        wrst = 1'b1;
        cycle();
        wrst = 1'b0;
        for (int i = 0; i < NREQ; i++) q[i].delete();
        dut_log.delete();
        q[0].push_back(8'h01);
        q[2].push_back(8'h02);
        settle("rst_done", 20);
        chk("rst_first", 32'(dut_log.size() != 0 ? dut_log[0] : -1), 32'd0);

        // Random traffic with stalls, almost-full, drops and occasional reset.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 9) < 3 && q[i].size() < 6) q[i].push_back(8'($urandom));
                if ($urandom_range(0, 99) < 3) drop[i] = ~drop[i];
            end
            ifc.wfull       = ($urandom_range(0, 4) == 0);
            ifc.walmostfull = ($urandom_range(0, 3) == 0);
            wrst            = ($urandom_range(0, 299) == 0);
            cycle();
        end
        wrst            = 1'b0;
        ifc.wfull       = 1'b0;
        ifc.walmostfull = 1'b0;
        drop            = '0;
        settle("drain", 300);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
